// File: rtl/bfly_op_sequencer.sv
// ---------------------------------------------------------------------------
// bfly_op_sequencer
//
// Front-panel controller for the FFT butterfly. The user loads six operands
// (A, B and twiddle W, real then imaginary) from the switch bus with the step
// button. The block then fires one butterfly, waits for completion (with a
// timeout), and lets the user page through the four result words.
//
// Ports
//   clk        system clock
//   nReset     asynchronous active-low reset
//   btn        debounced step button level (active high)
//   abort      debounced abort level (active high), returns to LOAD
//   sw         switch value captured into the current operand slot on a press
//   bfly_done  butterfly completion, only observed in WAIT
//   a_re..w_im operand registers driving the butterfly
//   bfly_start one-cycle start strobe (Moore, high while in START)
//   op_idx     operand slot loaded by the next press (0=a_re .. 5=w_im)
//   res_sel    result word to display (0=X_re,1=X_im,2=Y_re,3=Y_im)
//   state      LOAD=0, START=1, WAIT=2, SHOW=3
//   err        sticky completion-timeout flag
// ---------------------------------------------------------------------------
module bfly_op_sequencer #(
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic              clk,
   input  logic              nReset,
   input  logic              btn,
   input  logic              abort,
   input  logic [DATA_W-1:0] sw,
   input  logic              bfly_done,
   output logic [DATA_W-1:0] a_re,
   output logic [DATA_W-1:0] a_im,
   output logic [DATA_W-1:0] b_re,
   output logic [DATA_W-1:0] b_im,
   output logic [DATA_W-1:0] w_re,
   output logic [DATA_W-1:0] w_im,
   output logic              bfly_start,
   output logic [2:0]        op_idx,
   output logic [1:0]        res_sel,
   output logic [1:0]        state,
   output logic              err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_SHOW  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        op_idx_q, op_idx_d;
   logic [1:0]        res_sel_q, res_sel_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              err_q, err_d;
   logic              btn_q;
   logic              load_en;
   logic              press;
   logic [DATA_W-1:0] ops_q [6];

   // btn_q resets high so a button held across reset release is not a press.
   assign press = btn & ~btn_q;

   always_comb begin
      state_d   = state_q;
      op_idx_d  = op_idx_q;
      res_sel_d = res_sel_q;
      timer_d   = timer_q;
      err_d     = err_q;
      load_en   = 1'b0;
      if (abort) begin
         // Abort overrides everything, including a coincident press.
         state_d   = S_LOAD;
         op_idx_d  = 3'd0;
         res_sel_d = 2'd0;
         timer_d   = '0;
         err_d     = 1'b0;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (press) begin
                  load_en = 1'b1;
                  if (op_idx_q == 3'd5) begin
                     op_idx_d = 3'd0;
                     state_d  = S_START;
                  end else begin
                     op_idx_d = op_idx_q + 3'd1;
                  end
               end
            end
            S_START: begin
               state_d = S_WAIT;
               timer_d = '0;
               err_d   = 1'b0;
            end
            S_WAIT: begin
               // Completion wins over a timeout landing in the same cycle.
               if (bfly_done) begin
                  state_d   = S_SHOW;
                  res_sel_d = 2'd0;
               end else if (timer_q == TIMER_LAST) begin
                  state_d  = S_LOAD;
                  op_idx_d = 3'd0;
                  err_d    = 1'b1;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            S_SHOW: begin
               if (press) begin
                  if (res_sel_q == 2'd3) begin
                     res_sel_d = 2'd0;
                     op_idx_d  = 3'd0;
                     state_d   = S_LOAD;
                  end else begin
                     res_sel_d = res_sel_q + 2'd1;
                  end
               end
            end
            default: state_d = S_LOAD;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q   <= S_LOAD;
         op_idx_q  <= 3'd0;
         res_sel_q <= 2'd0;
         timer_q   <= '0;
         err_q     <= 1'b0;
         btn_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         op_idx_q  <= op_idx_d;
         res_sel_q <= res_sel_d;
         timer_q   <= timer_d;
         err_q     <= err_d;
         btn_q     <= btn;
      end
   end

   // Operands only change on a LOAD-state press, so they stay stable
   // throughout START/WAIT/SHOW and survive abort for re-editing.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         for (int i = 0; i < 6; i++) ops_q[i] <= '0;
      end else if (load_en) begin
         ops_q[op_idx_q] <= sw;
      end
   end

   assign a_re       = ops_q[0];
   assign a_im       = ops_q[1];
   assign b_re       = ops_q[2];
   assign b_im       = ops_q[3];
   assign w_re       = ops_q[4];
   assign w_im       = ops_q[5];
   assign bfly_start = (state_q == S_START);
   assign op_idx     = op_idx_q;
   assign res_sel    = res_sel_q;
   assign state      = state_q;
   assign err        = err_q;

endmodule

// File: tb/tb_bfly_op_sequencer.sv
module tb_bfly_op_sequencer;

   localparam int DW = 8;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          nReset = 1'b0;
   logic          btn = 1'b0;
   logic          abort = 1'b0;
   logic [DW-1:0] sw = '0;
   logic          bfly_done = 1'b0;
   logic [DW-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
   logic          bfly_start;
   logic [2:0]    op_idx;
   logic [1:0]    res_sel;
   logic [1:0]    state;
   logic          err;

   logic [DW-1:0] ops_act [6];
   logic [DW-1:0] exp_ops [6];

   int n_cmp = 0;
   int n_bad = 0;

   bfly_op_sequencer #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .nReset(nReset), .btn(btn), .abort(abort), .sw(sw),
      .bfly_done(bfly_done),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
      .bfly_start(bfly_start), .op_idx(op_idx), .res_sel(res_sel),
      .state(state), .err(err)
   );

   always #5 clk = ~clk;

   always_comb begin
      ops_act[0] = a_re;
      ops_act[1] = a_im;
      ops_act[2] = b_re;
      ops_act[3] = b_im;
      ops_act[4] = w_re;
      ops_act[5] = w_im;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One press: button high for one cycle then low for one cycle.
   task automatic press(input logic [DW-1:0] v);
      sw  = v;
      btn = 1'b1;
      tick();
      btn = 1'b0;
      tick();
   endtask

   // Load all six slots; ends one cycle into WAIT.
   task automatic load_six(input logic [DW-1:0] base);
      for (int i = 0; i < 6; i++) begin
         press(base + DW'(i));
         exp_ops[i] = base + DW'(i);
      end
   endtask

   task automatic test_reset();
      nReset = 1'b0;
      btn    = 1'b1;
      sw     = 8'h5A;
      repeat (3) tick();
      nReset = 1'b1;
      repeat (10) tick();
      n_cmp++;
      if (op_idx !== 3'd0) begin n_bad++; $display("FAIL reset_op_idx: got %0d want 0", op_idx); end
      n_cmp++;
      if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
      n_cmp++;
      if ({bfly_start, err, res_sel} !== 4'b0) begin
         n_bad++; $display("FAIL reset_ctrl: start=%b err=%b res_sel=%0d want 0", bfly_start, err, res_sel);
      end
      for (int i = 0; i < 6; i++) begin
         exp_ops[i] = '0;
         n_cmp++;
         if (ops_act[i] !== exp_ops[i]) begin n_bad++; $display("FAIL reset_op%0d: got %h want 00", i, ops_act[i]); end
      end
      btn = 1'b0;
      tick();
   endtask

   task automatic test_load();
      logic [DW-1:0] v;
      for (int i = 0; i < 5; i++) begin
         v = DW'(8'h11 * (i + 1));
         press(v);
         exp_ops[i] = v;
         n_cmp++;
         if (op_idx !== 3'(i + 1)) begin n_bad++; $display("FAIL load_idx%0d: got %0d want %0d", i, op_idx, i + 1); end
      end
      sw  = 8'h66;
      btn = 1'b1;
      tick();
      exp_ops[5] = 8'h66;
      n_cmp++;
      if ({state, bfly_start, op_idx} !== {2'd1, 1'b1, 3'd0}) begin
         n_bad++; $display("FAIL load_start: state=%0d start=%b idx=%0d want 1/1/0", state, bfly_start, op_idx);
      end
      btn = 1'b0;
      tick();
      n_cmp++;
      if ({state, bfly_start} !== {2'd2, 1'b0}) begin
         n_bad++; $display("FAIL load_wait: state=%0d start=%b want 2/0", state, bfly_start);
      end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (ops_act[i] !== exp_ops[i]) begin n_bad++; $display("FAIL load_op%0d: got %h want %h", i, ops_act[i], exp_ops[i]); end
      end
   endtask

   task automatic test_done_show();
      repeat (4) tick();
      bfly_done = 1'b1;
      tick();
      bfly_done = 1'b0;
      n_cmp++;
      if ({state, res_sel, err} !== {2'd3, 2'd0, 1'b0}) begin
         n_bad++; $display("FAIL done_show: state=%0d res=%0d err=%b want 3/0/0", state, res_sel, err);
      end
      for (int k = 1; k <= 3; k++) begin
         press(8'hFF);
         n_cmp++;
         if ({state, res_sel} !== {2'd3, 2'(k)}) begin
            n_bad++; $display("FAIL show_page%0d: state=%0d res=%0d want 3/%0d", k, state, res_sel, k);
         end
      end
      press(8'hFF);
      n_cmp++;
      if ({state, op_idx, res_sel} !== {2'd0, 3'd0, 2'd0}) begin
         n_bad++; $display("FAIL show_exit: state=%0d idx=%0d res=%0d want 0/0/0", state, op_idx, res_sel);
      end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (ops_act[i] !== exp_ops[i]) begin n_bad++; $display("FAIL show_op%0d: got %h want %h", i, ops_act[i], exp_ops[i]); end
      end
   endtask

   task automatic test_timeout();
      load_six(8'h01);
      for (int k = 1; k <= TO - 1; k++) begin
         tick();
         n_cmp++;
         if (state !== 2'd2) begin n_bad++; $display("FAIL to_wait%0d: state=%0d want 2", k, state); end
      end
      tick();
      n_cmp++;
      if ({state, op_idx, err} !== {2'd0, 3'd0, 1'b1}) begin
         n_bad++; $display("FAIL to_expire: state=%0d idx=%0d err=%b want 0/0/1", state, op_idx, err);
      end
      for (int i = 0; i < 5; i++) begin
         press(8'h21 + DW'(i));
         exp_ops[i] = 8'h21 + DW'(i);
      end
      n_cmp++;
      if (err !== 1'b1) begin n_bad++; $display("FAIL to_sticky: err=%b want 1", err); end
      press(8'h26);
      exp_ops[5] = 8'h26;
      n_cmp++;
      if ({state, err} !== {2'd2, 1'b0}) begin
         n_bad++; $display("FAIL to_clear: state=%0d err=%b want 2/0", state, err);
      end
   endtask

   // Entered with the DUT in WAIT, timer = 0.
   task automatic test_ignore_and_coincident();
      press(8'hEE);
      n_cmp++;
      if ({state, op_idx, res_sel} !== {2'd2, 3'd0, 2'd0}) begin
         n_bad++; $display("FAIL wait_press: state=%0d idx=%0d res=%0d want 2/0/0", state, op_idx, res_sel);
      end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (ops_act[i] !== exp_ops[i]) begin n_bad++; $display("FAIL wait_op%0d: got %h want %h", i, ops_act[i], exp_ops[i]); end
      end
      repeat (TO - 3) tick();
      bfly_done = 1'b1;
      tick();
      bfly_done = 1'b0;
      n_cmp++;
      if ({state, err} !== {2'd3, 1'b0}) begin
         n_bad++; $display("FAIL coincident: state=%0d err=%b want 3/0", state, err);
      end
      press(8'h00);
      bfly_done = 1'b1;
      tick();
      bfly_done = 1'b0;
      n_cmp++;
      if ({state, res_sel} !== {2'd3, 2'd1}) begin
         n_bad++; $display("FAIL show_done: state=%0d res=%0d want 3/1", state, res_sel);
      end
      repeat (3) press(8'h00);
      bfly_done = 1'b1;
      tick();
      bfly_done = 1'b0;
      n_cmp++;
      if ({state, op_idx} !== {2'd0, 3'd0}) begin
         n_bad++; $display("FAIL load_done: state=%0d idx=%0d want 0/0", state, op_idx);
      end
   endtask

   task automatic test_abort();
      for (int i = 0; i < 3; i++) begin
         press(8'hA1 + DW'(i));
         exp_ops[i] = 8'hA1 + DW'(i);
      end
      abort = 1'b1;
      btn   = 1'b1;
      sw    = 8'hAA;
      tick();
      abort = 1'b0;
      btn   = 1'b0;
      n_cmp++;
      if ({state, op_idx} !== {2'd0, 3'd0}) begin
         n_bad++; $display("FAIL abort_load: state=%0d idx=%0d want 0/0", state, op_idx);
      end
      n_cmp++;
      if (b_im !== exp_ops[3]) begin n_bad++; $display("FAIL abort_slot3: got %h want %h", b_im, exp_ops[3]); end
      tick();
      load_six(8'h30);
      repeat (TO) tick();
      n_cmp++;
      if (err !== 1'b1) begin n_bad++; $display("FAIL abort_pre_err: err=%b want 1", err); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_cmp++;
      if (err !== 1'b0) begin n_bad++; $display("FAIL abort_err: err=%b want 0", err); end
      load_six(8'h40);
      repeat (3) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_cmp++;
      if ({state, bfly_start, op_idx} !== {2'd0, 1'b0, 3'd0}) begin
         n_bad++; $display("FAIL abort_wait: state=%0d start=%b idx=%0d want 0/0/0", state, bfly_start, op_idx);
      end
      tick();
      n_cmp++;
      if ({state, bfly_start} !== {2'd0, 1'b0}) begin
         n_bad++; $display("FAIL abort_after: state=%0d start=%b want 0/0", state, bfly_start);
      end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (ops_act[i] !== exp_ops[i]) begin n_bad++; $display("FAIL abort_op%0d: got %h want %h", i, ops_act[i], exp_ops[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_done_show();
      test_timeout();
      test_ignore_and_coincident();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bfly_op_sequencer.md
Name: bfly_op_sequencer

Overview:
Front-panel controller for the FFT butterfly. It takes a debounced push-button level and the slide-switch bus. It steps the user through loading six operands (A, B and twiddle W, each as real and imaginary), then fires one butterfly computation and waits for completion. The user then pages through the four result words with the same button. It sits between the debounce instances and the butterfly datapath, with a completion timeout and an abort path.

Parameters:
DATA_W, 8, width of switch bus and of each operand register
TIMEOUT_CYCLES, 1023, maximum cycles spent in WAIT before declaring an error (must be >= 2)

Ports:
clk  input  1  system clock
nReset  input  1  asynchronous active-low reset
btn  input  1  debounced step button level (active high)
abort  input  1  debounced abort level (active high)
sw  input  DATA_W  switch value captured on a step press
bfly_done  input  1  butterfly completion pulse/level
a_re, a_im, b_re, b_im, w_re, w_im  output  DATA_W each  operand registers driving the butterfly
bfly_start  output  1  one-cycle start strobe to the butterfly
op_idx  output  3  operand slot loaded on next press (0=a_re,1=a_im,2=b_re,3=b_im,4=w_re,5=w_im)
res_sel  output  2  result word to display (0=X_re,1=X_im,2=Y_re,3=Y_im)
state  output  2  current state for LEDs: LOAD=0, START=1, WAIT=2, SHOW=3
err  output  1  sticky timeout flag

Behaviour:
- Reset values: all operands 0, op_idx 0, res_sel 0, state LOAD, bfly_start 0, err 0, wait timer 0, btn_q 1.
- Edge detect: btn_q <= btn every cycle, in every state including abort.
  - press = btn & ~btn_q.
  - btn_q resets to 1, so a button held through reset release does not produce a press.
- All state and register updates occur at the clock edge where press is high. Results are visible the next cycle, giving 1-cycle latency from btn rising to op_idx/operand change.
- abort has priority over everything except reset. While abort=1, on each edge:
  - state <= LOAD, op_idx <= 0, res_sel <= 0, timer <= 0, err <= 0.
  - Operands are retained.
  - A press in the same cycle is ignored.
- LOAD:
  - On press, operand[op_idx] <= sw.
  - If op_idx==5, then op_idx <= 0 and state <= START; else op_idx <= op_idx+1.
  - op_idx never reaches 6 or 7.
- START:
  - bfly_start = 1 exactly while in START, which is always one cycle (Moore output).
  - Next state is WAIT; timer <= 0; err <= 0.
  - Presses are ignored.
- WAIT:
  - Presses are ignored.
  - If bfly_done=1, then state <= SHOW and res_sel <= 0.
  - Else if timer == TIMEOUT_CYCLES-1, then state <= LOAD, op_idx <= 0, err <= 1.
  - Else timer <= timer+1.
  - bfly_done in the same cycle as the timeout: done wins, and err stays 0.
  - Timer width is $clog2(TIMEOUT_CYCLES+1).
- SHOW:
  - On press, if res_sel==3, then res_sel <= 0, op_idx <= 0, state <= LOAD. Else res_sel <= res_sel+1.
  - Operands are retained for re-editing.
- bfly_done is ignored in every state except WAIT.
- err is sticky: it is cleared only by reset, abort, or entering WAIT via START.
- Operands never change outside LOAD-state presses. They are stable for the whole START/WAIT/SHOW span.

Test Plan:
- Reset with btn held high, release nReset, hold btn 10 cycles -> no press; op_idx=0, state=0, all operands 0.
- Six presses with sw=0x11,0x22,0x33,0x44,0x55,0x66 -> a_re..w_im hold those values; op_idx steps 0..5 then 0; state goes to 1 for exactly one cycle with bfly_start=1, then to 2.
- In WAIT, pulse bfly_done 5 cycles after start -> state=3, res_sel=0, err=0. Four presses -> res_sel 1,2,3, then state=0, op_idx=0, operands unchanged.
- TIMEOUT_CYCLES=8, never assert bfly_done -> state returns to 0 exactly 8 cycles after entering WAIT, err=1. Next load sequence and START clear err.
- Presses during WAIT, and bfly_done during LOAD/SHOW -> no change to state, op_idx, res_sel or operands. bfly_done coincident with the final timeout cycle -> state=3, err=0.
- Assert abort at op_idx=3, together with a press and sw=0xAA -> state=0, op_idx=0, operand slot 3 unchanged. Abort during WAIT -> state=0, timer cleared, bfly_start stays 0.
